// File: rtl/ofdm_packet_detector.sv
// Delay-and-correlate OFDM short-preamble detector; samples pass through with zero latency.
// Define OFDM_DETECT_COUNT_EN to build the saturating detection counter on o_detect_count.
module ofdm_packet_detector #(
  parameter int WIDTH       = 32,
  parameter int LAG         = 16,
  parameter int WINDOW      = 16,
  parameter int MIN_PLATEAU = 32,
  parameter int HOLDOFF_LEN = 1024,
  parameter int POWER_FLOOR = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       threshold,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      o_detect_count
);

  localparam int HW    = WIDTH / 2;
  localparam int PW    = 2 * HW + 1;
  localparam int AW    = PW + $clog2(WINDOW);
  localparam int DEPTH = LAG + WINDOW;
  localparam int FCW   = $clog2(DEPTH + 1);
  localparam int PCW   = $clog2(MIN_PLATEAU + 1);
  localparam int HCW   = $clog2(HOLDOFF_LEN + 1);
  localparam int MW    = AW + 9;

  localparam logic [FCW-1:0] FILL_LAST = FCW'(DEPTH - 1);
  localparam logic [PCW-1:0] PLAT_LAST = PCW'(MIN_PLATEAU - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLDOFF_LEN - 1);
  localparam logic [AW-1:0]  R_FLOOR   = AW'(POWER_FLOOR);

  typedef enum logic [1:0] {
    S_FILL,
    S_SEARCH,
    S_PLATEAU,
    S_HOLDOFF
  } state_t;

  // x * conj(y), returned as {re, im}, each PW bits signed.
  function automatic logic [2*PW-1:0] corr_term(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic signed [2*HW-1:0] xi, xq, yi, yq, ac, bd, bc, ad;
    logic [PW-1:0] re, im;
    xi = {{HW{x[WIDTH-1]}}, x[WIDTH-1:HW]};
    xq = {{HW{x[HW-1]}}, x[HW-1:0]};
    yi = {{HW{y[WIDTH-1]}}, y[WIDTH-1:HW]};
    yq = {{HW{y[HW-1]}}, y[HW-1:0]};
    ac = xi * yi;
    bd = xq * yq;
    bc = xq * yi;
    ad = xi * yq;
    re = {ac[2*HW-1], ac} + {bd[2*HW-1], bd};
    im = {bc[2*HW-1], bc} - {ad[2*HW-1], ad};
    return {re, im};
  endfunction

  function automatic logic [PW-1:0] energy(input logic [WIDTH-1:0] x);
    logic signed [2*HW-1:0] xi, xq, ii, qq;
    xi = {{HW{x[WIDTH-1]}}, x[WIDTH-1:HW]};
    xq = {{HW{x[HW-1]}}, x[HW-1:0]};
    ii = xi * xi;
    qq = xq * xq;
    return {1'b0, ii} + {1'b0, qq};
  endfunction

  function automatic logic [AW-1:0] abs_sat(input logic [AW-1:0] v);
    if (v == {1'b1, {(AW-1){1'b0}}}) return {1'b0, {(AW-1){1'b1}}};
    else if (v[AW-1])                return -v;
    else                             return v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dl_q [DEPTH];
  logic [AW-1:0]    p_re_q, p_re_d, p_im_q, p_im_d, r_q, r_d;
  logic [PCW-1:0]   plat_q, plat_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [FCW-1:0]   fill_cnt_q, fill_cnt_d;
  logic             fill_done_q, fill_done_d;

  logic [2*PW-1:0]  new_t, old_t;
  logic [PW-1:0]    new_e, old_e;
  logic [AW-1:0]    abs_re, abs_im;
  logic [AW:0]      mag_sum;
  logic [MW-1:0]    lhs, rhs;
  logic             accept, above, tlast_raw, detect;
  logic             unused_tlast;

  assign o_tdata      = i_tdata;
  assign o_tvalid     = i_tvalid;
  assign i_tready     = o_tready;
  assign accept       = i_tvalid & o_tready;
  assign unused_tlast = i_tlast;

  // Running window sums: newest product enters, the one WINDOW samples older leaves.
  always_comb begin
    new_t  = corr_term(i_tdata, dl_q[LAG-1]);
    old_t  = corr_term(dl_q[WINDOW-1], dl_q[DEPTH-1]);
    new_e  = energy(i_tdata);
    old_e  = energy(dl_q[WINDOW-1]);
    p_re_d = p_re_q + {{(AW-PW){new_t[2*PW-1]}}, new_t[2*PW-1:PW]}
                    - {{(AW-PW){old_t[2*PW-1]}}, old_t[2*PW-1:PW]};
    p_im_d = p_im_q + {{(AW-PW){new_t[PW-1]}}, new_t[PW-1:0]}
                    - {{(AW-PW){old_t[PW-1]}}, old_t[PW-1:0]};
    r_d    = r_q + {{(AW-PW){1'b0}}, new_e} - {{(AW-PW){1'b0}}, old_e};
  end

  always_comb begin
    abs_re  = abs_sat(p_re_q);
    abs_im  = abs_sat(p_im_q);
    mag_sum = {1'b0, abs_re} + {1'b0, abs_im};
    lhs     = {mag_sum, 8'h00};
    rhs     = {1'b0, {{AW{1'b0}}, threshold} * {8'h00, r_q}};
    above   = fill_done_q && (r_q >= R_FLOOR) && (lhs >= rhs);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_re_q <= '0;
      p_im_q <= '0;
      r_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dl_q[i] <= '0;
    end else if (accept) begin
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
      r_q     <= r_d;
      dl_q[0] <= i_tdata;
      for (int unsigned i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign tlast_raw = ((state_q == S_PLATEAU) || (MIN_PLATEAU == 1 && state_q == S_SEARCH))
                     && above && (plat_q == PLAT_LAST);
  assign detect    = accept & tlast_raw;
  assign o_tlast   = tlast_raw & ~reset;

  always_comb begin
    state_d     = state_q;
    plat_d      = plat_q;
    hold_d      = hold_q;
    fill_cnt_d  = fill_cnt_q;
    fill_done_d = fill_done_q;
    if (detect) begin
      state_d = S_HOLDOFF;
      hold_d  = '0;
      plat_d  = '0;
    end else if (accept) begin
      case (state_q)
        S_FILL: begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = S_SEARCH;
            fill_done_d = 1'b1;
          end
        end
        S_SEARCH: begin
          if (above) begin
            plat_d  = PCW'(1);
            state_d = S_PLATEAU;
          end
        end
        S_PLATEAU: begin
          if (!above) begin
            plat_d  = '0;
            state_d = S_SEARCH;
          end else begin
            plat_d = plat_q + 1'b1;
          end
        end
        S_HOLDOFF: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) state_d = S_SEARCH;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      plat_q      <= '0;
      hold_q      <= '0;
      fill_cnt_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      plat_q      <= plat_d;
      hold_q      <= hold_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_done_q <= fill_done_d;
    end
  end

`ifdef OFDM_DETECT_COUNT_EN
  logic [15:0] det_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                           det_cnt_q <= '0;
    else if (detect && det_cnt_q != '1)  det_cnt_q <= det_cnt_q + 1'b1;
  end

  assign o_detect_count = det_cnt_q;
`else
  assign o_detect_count = '0;
`endif

endmodule

// File: doc/ofdm_packet_detector.md
# ofdm_packet_detector

Delay-and-correlate OFDM packet detector sitting directly upstream of the OFDM framer. Sample data passes straight through with zero latency. The detector marks the sample on which a short-preamble plateau is confirmed by asserting `o_tlast`. The framer treats that beat as start-of-packet.

## Interface

**Parameters**
- `WIDTH` = 32: sample width; I in [31:16], Q in [15:0], both signed two's complement.
- `LAG` = 16: short-preamble period in samples (correlation lag).
- `WINDOW` = 16: correlation window length; must be a power of two.
- `MIN_PLATEAU` = 32: consecutive above-threshold accepted samples required to declare a detection.
- `HOLDOFF_LEN` = 1024: accepted samples ignored after a detection.
- `POWER_FLOOR` = 1024: minimum window energy R for the metric to count as above threshold.

**Ports**
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `threshold` input 8: unsigned Q0.8 detection ratio; sampled every cycle.
- `i_tdata` input WIDTH: input sample.
- `i_tlast` input 1: ignored.
- `i_tvalid` input 1: input valid.
- `i_tready` output 1: input ready.
- `o_tdata` output WIDTH: output sample.
- `o_tlast` output 1: detection marker.
- `o_tvalid` output 1: output valid.
- `o_tready` input 1: output ready.
- `o_detect_count` output 16: detections since reset (see Configuration).

## Operation

- **Pass-through:** `o_tdata = i_tdata`, `o_tvalid = i_tvalid`, `i_tready = o_tready`.
- **Accept:** a sample is accepted when `i_tvalid & o_tready`. All state advances only on accept.
- **Delay line:** holds the last LAG+WINDOW accepted samples.
- **Correlation P** (complex):
  - Sum over the last WINDOW accepted samples of x(n)·conj(x(n−LAG)).
  - Each product is 33 bits signed per component; accumulator is 33+log2(WINDOW) bits.
  - Updated as a running sum: add the newest product, subtract the product leaving the window.
- **Energy R:** sum over the same WINDOW of |x(n)|² = I²+Q², unsigned, with the same accumulator width.
- **`above`** (combinational from registered P and R):
  - `above = fill_done && R >= POWER_FLOOR && 256·(|Re P|+|Im P|) >= threshold·R`.
  - Compute at full width with no truncation.
  - |·| of the most-negative value saturates to the maximum positive value.

**State machine** (all transitions occur on accept only):
- **S_FILL:** count accepts. After LAG+WINDOW accepts, go to S_SEARCH and set `fill_done`.
- **S_SEARCH:** on an accept with `above`, set `plat_cnt` = 1 and go to S_PLATEAU. If MIN_PLATEAU = 1, detect immediately instead.
- **S_PLATEAU:**
  - On an accept with `!above`: `plat_cnt` = 0, go to S_SEARCH.
  - On an accept with `above` and `plat_cnt == MIN_PLATEAU−1`: detect.
  - Otherwise on an accept with `above`: increment `plat_cnt`.
- **Detect:**
  - `o_tlast` = 1 on that same beat.
  - `hold_cnt` = 0; go to S_HOLDOFF.
  - Increment `o_detect_count`, saturating at 0xFFFF.
- **S_HOLDOFF:** increment `hold_cnt` on each accept. When the HOLDOFF_LEN-th accept after the detection occurs, go to S_SEARCH.
- **`o_tlast` definition:** `(state==S_PLATEAU || MIN_PLATEAU==1 && state==S_SEARCH) && above && plat_cnt==MIN_PLATEAU−1`. It is never asserted in S_FILL or S_HOLDOFF.

## Timing

- **Data latency:** 0 cycles (combinational pass-through).
- **`above` window:** during the acceptance of sample n, `above` reflects samples up to n−1, since P and R register on accept.
- **Reset values:**
  - state = S_FILL.
  - P = 0, R = 0, delay line = 0.
  - `plat_cnt` = 0, `hold_cnt` = 0, fill count = 0, `fill_done` = 0.
  - `o_detect_count` = 0; `o_tlast` = 0.
  - `o_tvalid` and `i_tready` follow their inputs during reset.
- **Reset mid-packet:** all of the above state clears; the next detection requires a full refill.
- **Backpressure:** a stalled beat holds `o_tlast` and all state stable until it is accepted. `threshold` changes take effect on the next cycle's `above`.

## Configuration

- **`OFDM_DETECT_COUNT_EN` defined:** `o_detect_count` counts detections as described above.
- **Undefined:** `o_detect_count` is tied to 0 and no counter register is instantiated. All other behaviour is identical.

## Test plan

- **Reset:** assert `reset` for 4 cycles with `i_tvalid` = 1 → `o_tlast` = 0, `o_detect_count` = 0, and `o_tdata` tracks `i_tdata`.
- **Clean preamble:** `threshold` = 0xC0; stream a period-16 sequence with |I|,|Q| ≈ 8000 continuously from reset, with `o_tready` = 1 → exactly one `o_tlast` in the first 1100 beats, at accepted index 63 (0-based). Next `o_tlast` at index 1119.
- **Backpressure:** same stimulus with `o_tready` toggling on a pseudo-random pattern → `o_tlast` on the same accepted indices (63, 1119), with no dropped or duplicated beats.
- **Noise and silence:** 5000 samples of uniform random 16-bit noise → no `o_tlast`. 5000 zero samples → no `o_tlast` (R < POWER_FLOOR).
- **Plateau break:** periodic signal for 40 samples, one 16-sample burst of random noise, then periodic again → no detection on the first segment. `o_tlast` occurs 32 above-accepts after the metric recovers.
- **Mid-plateau reset:** assert `reset` at accepted index 50 of the clean preamble → no `o_tlast` at 63. Detection occurs at index 63 counted from the post-reset accepts.
